// File: rtl/operand_stream_tx.sv
// Walks the x/y/ch_in/ch_out/k_v/k_h loop nest, fetches operands and presents (a, b) pairs.
// Optional macro TX_TRANSFER_COUNT_EN adds an accepted-pair counter on tx_count.
module operand_stream_tx #(
    parameter int LOG2_OF_MEM_HEIGHT = 20,
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int INPUT_NB_CHANNELS  = 64,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                          clk,
    input  logic                          arst_in,
    input  logic                          start,
    output logic                          running,
    output logic                          done,
    output logic                          fm_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] fm_addr,
    input  logic [DATA_WIDTH-1:0]         fm_rdata,
    output logic                          k_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] k_addr,
    input  logic [DATA_WIDTH-1:0]         k_rdata,
    output logic [DATA_WIDTH-1:0]         a_data,
    output logic [DATA_WIDTH-1:0]         b_data,
    output logic                          a_valid,
    output logic                          b_valid,
    input  logic                          a_ready,
    input  logic                          b_ready,
    output logic [31:0]                   tx_count
);

    localparam int P  = KERNEL_SIZE / 2;
    localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int IW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
    localparam int OW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
    localparam int KW = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1;

    localparam logic [XW-1:0] X_MAX  = XW'(FEATURE_MAP_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [IW-1:0] CI_MAX = IW'(INPUT_NB_CHANNELS - 1);
    localparam logic [OW-1:0] CO_MAX = OW'(OUTPUT_NB_CHANNELS - 1);
    localparam logic [KW-1:0] K_MAX  = KW'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {IDLE, READ, PRESENT} state_t;

    state_t          state;
    logic [XW-1:0]   x, x_n;
    logic [YW-1:0]   y, y_n;
    logic [IW-1:0]   ci, ci_n;
    logic [OW-1:0]   co, co_n;
    logic [KW-1:0]   kv, kv_n;
    logic [KW-1:0]   kh, kh_n;
    logic            oob, oob_n;
    logic            w_kh, w_kv, w_co, w_ci, w_y, last;
    logic            xfer, launch;
    int              x_in, y_in, fm_addr_full, k_addr_full;

    // Carry chain of the loop nest; innermost (k_h) first.
    assign w_kh = (kh == K_MAX);
    assign w_kv = w_kh && (kv == K_MAX);
    assign w_co = w_kv && (co == CO_MAX);
    assign w_ci = w_co && (ci == CI_MAX);
    assign w_y  = w_ci && (y == Y_MAX);
    assign last = w_y && (x == X_MAX);

    assign xfer   = (state == PRESENT) && a_ready && b_ready;
    assign launch = ((state == IDLE) && start) || (xfer && !last);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        x_n  = x;
        y_n  = y;
        ci_n = ci;
        co_n = co;
        kv_n = kv;
        kh_n = kh;
        if (state == IDLE) begin
            x_n  = '0;
            y_n  = '0;
            ci_n = '0;
            co_n = '0;
            kv_n = '0;
            kh_n = '0;
        end else begin
            kh_n = w_kh ? '0 : kh + KW'(1);
            if (w_kh) kv_n = w_kv ? '0 : kv + KW'(1);
            if (w_kv) co_n = w_co ? '0 : co + OW'(1);
            if (w_co) ci_n = w_ci ? '0 : ci + IW'(1);
            if (w_ci) y_n  = w_y  ? '0 : y + YW'(1);
            if (w_y)  x_n  = last ? '0 : x + XW'(1);
        end

        x_in  = int'(x_n) + int'(kh_n) - P;
        y_in  = int'(y_n) + int'(kv_n) - P;
        oob_n = (x_in < 0) || (x_in >= FEATURE_MAP_WIDTH) ||
                (y_in < 0) || (y_in >= FEATURE_MAP_HEIGHT);
        fm_addr_full = ((y_in * FEATURE_MAP_WIDTH) + x_in) * INPUT_NB_CHANNELS + int'(ci_n);
        k_addr_full  = ((int'(co_n) * INPUT_NB_CHANNELS + int'(ci_n)) * KERNEL_SIZE
                        + int'(kv_n)) * KERNEL_SIZE + int'(kh_n);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            ci      <= '0;
            co      <= '0;
            kv      <= '0;
            kh      <= '0;
            oob     <= 1'b0;
            done    <= 1'b0;
            fm_re   <= 1'b0;
            k_re    <= 1'b0;
            fm_addr <= '0;
            k_addr  <= '0;
        end else begin
            done  <= 1'b0;
            fm_re <= 1'b0;
            k_re  <= 1'b0;

            if (launch || xfer) begin
                x  <= x_n;
                y  <= y_n;
                ci <= ci_n;
                co <= co_n;
                kv <= kv_n;
                kh <= kh_n;
            end

            // Out-of-image taps never touch the feature-map SRAM.
            if (launch) begin
                k_re    <= 1'b1;
                fm_re   <= !oob_n;
                oob     <= oob_n;
                k_addr  <= LOG2_OF_MEM_HEIGHT'(k_addr_full);
                fm_addr <= oob_n ? '0 : LOG2_OF_MEM_HEIGHT'(fm_addr_full);
            end

            case (state)
                IDLE:    if (start) state <= READ;
                READ:    state <= PRESENT;
                PRESENT: begin
                    if (xfer) begin
                        state <= last ? IDLE : READ;
                        done  <= last;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign running = (state != IDLE);
    assign a_valid = (state == PRESENT);
    assign b_valid = a_valid;
    assign a_data  = (a_valid && !oob) ? fm_rdata : '0;
    assign b_data  = a_valid ? k_rdata : '0;

`ifdef TX_TRANSFER_COUNT_EN
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in)                    tx_count <= '0;
        else if ((state == IDLE) && start) tx_count <= '0;
        else if (xfer)                  tx_count <= tx_count + 32'd1;
    end
`else
    assign tx_count = '0;
`endif

endmodule
